packet_wrr_arbiter: RTL and testbench



---
 rtl/packet_mux_pkg.sv | 5 +
 rtl/packet_wrr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_packet_wrr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_mux_pkg.sv
// Shared beat-format widths for the packet mux family.
package packet_mux_pkg;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
endpackage

// File: rtl/packet_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter: merges NUM_PORTS packet
// streams onto one output. A granted port keeps the output until its EOP beat
// is accepted. Each port may send up to cfg_weight packets per turn.
module packet_wrr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = packet_mux_pkg::DATA_W,
    parameter int EMPTY_W   = packet_mux_pkg::EMPTY_W,
    parameter int WEIGHT_W  = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS-1:0]          in_sop,
    input  logic [NUM_PORTS-1:0]          in_eop,
    input  logic [NUM_PORTS-1:0]          in_error,
    input  logic [NUM_PORTS*EMPTY_W-1:0]  in_empty,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [EMPTY_W-1:0]            out_empty,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          out_error,
    input  logic                          out_ready,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
    output logic [PORT_W-1:0]             grant_idx,
    output logic                          busy,
    output logic [15:0]                   drop_cnt
);

    // One extra bit so rr_ptr + offset can be wrapped without overflow.
    localparam int CW = PORT_W + 1;

    typedef enum logic {ST_IDLE, ST_FORWARD} state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]   grant_idx_q, grant_idx_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0]   port_data   [NUM_PORTS];
    logic [EMPTY_W-1:0]  port_empty  [NUM_PORTS];
    logic [WEIGHT_W-1:0] port_weight [NUM_PORTS];

    logic [PORT_W-1:0]   sel;
    logic                sel_found;
    logic [CW-1:0]       cand;
    logic [PORT_W-1:0]   cur;
    logic                pass;
    logic                drop;
    logic                complete;
    logic [WEIGHT_W-1:0] eff;

    // Unpack flattened per-port buses; a zero weight counts as one packet.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi]   = in_data[gi*DATA_W +: DATA_W];
            assign port_empty[gi]  = in_empty[gi*EMPTY_W +: EMPTY_W];
            assign port_weight[gi] = (cfg_weight[gi*WEIGHT_W +: WEIGHT_W] == '0)
                                   ? WEIGHT_W'(1)
                                   : cfg_weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    // Rotating priority search starting at rr_ptr; descending loop so the
    // closest valid port to rr_ptr is the last (winning) assignment.
    always_comb begin
        sel       = rr_ptr_q;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_PORTS)) begin
                cand = cand - CW'(NUM_PORTS);
            end
            if (in_valid[cand[PORT_W-1:0]]) begin
                sel       = cand[PORT_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    // Next-state, handshake, turn bookkeeping and drop counting.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        credit_d    = credit_q;
        grant_idx_d = grant_idx_q;
        drop_cnt_d  = drop_cnt_q;
        cur         = sel;
        pass        = 1'b0;
        drop        = 1'b0;
        complete    = 1'b0;
        eff         = '0;
        in_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                cur = sel;
                if (sel_found && in_sop[sel]) begin
                    pass          = 1'b1;
                    in_ready[sel] = out_ready;
                    if (out_ready) begin
                        grant_idx_d = sel;
                        if (in_eop[sel]) begin
                            complete = 1'b1;
                        end else begin
                            state_d = ST_FORWARD;
                        end
                    end
                end else if (sel_found) begin
                    // Beat without SOP outside a packet: swallow it silently.
                    in_ready[sel] = 1'b1;
                    drop          = 1'b1;
                end
            end
            ST_FORWARD: begin
                cur           = grant_idx_q;
                pass          = in_valid[grant_idx_q];
                in_ready[grant_idx_q] = out_ready;
                if (in_valid[grant_idx_q] && out_ready && in_eop[grant_idx_q]) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // Remaining credit only applies if the finishing port owns the turn;
        // otherwise a fresh turn starts with that port's current weight.
        if (complete) begin
            eff = ((cur == rr_ptr_q) && (credit_q != '0)) ? credit_q : port_weight[cur];
            if (eff == WEIGHT_W'(1)) begin
                rr_ptr_d = (cur == PORT_W'(NUM_PORTS - 1)) ? '0 : cur + 1'b1;
                credit_d = '0;
            end else begin
                rr_ptr_d = cur;
                credit_d = eff - WEIGHT_W'(1);
            end
        end

        if (!rst_n) begin
            in_ready = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            credit_q    <= '0;
            grant_idx_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
            grant_idx_q <= grant_idx_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = rst_n & pass;
    assign out_data  = port_data[cur];
    assign out_empty = port_empty[cur];
    assign out_sop   = in_sop[cur];
    assign out_eop   = in_eop[cur];
    assign out_error = in_error[cur];
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == ST_FORWARD);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_packet_wrr_arbiter.sv
// Directed, table-driven bench for packet_wrr_arbiter (4 ports).
module tb_packet_wrr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int WW = 4;
    localparam int PW = 2;

    logic            clk;
    logic            rst_n;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid, in_sop, in_eop, in_error, in_ready;
    logic [N*EW-1:0] in_empty;
    logic [DW-1:0]   out_data;
    logic [EW-1:0]   out_empty;
    logic            out_valid, out_sop, out_eop, out_error, out_ready;
    logic [N*WW-1:0] cfg_weight;
    logic [PW-1:0]   grant_idx;
    logic            busy;
    logic [15:0]     drop_cnt;

    int n_vec;
    int n_fail;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic        ordy;
        logic [15:0] w;
        logic        ovalid;
        int          port;
        logic [3:0]  rdy;
        logic [1:0]  grant;
        logic        busy;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[$];

    packet_wrr_arbiter #(
        .NUM_PORTS(N), .DATA_W(DW), .EMPTY_W(EW), .WEIGHT_W(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_error(in_error), .in_empty(in_empty),
        .in_ready(in_ready),
        .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
        .out_ready(out_ready),
        .cfg_weight(cfg_weight), .grant_idx(grant_idx), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] port_word(input int p);
        return 32'hD000_0000 + 32'(p);
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                         input logic r, input logic [15:0] w);
        in_valid   = v;
        in_sop     = s;
        in_eop     = e;
        out_ready  = r;
        cfg_weight = w;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW]  = port_word(i);
            in_empty[i*EW +: EW] = 2'(i);
            in_error[i]          = (i % 2) == 1;
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                       input logic r, input logic [15:0] w, input logic ov, input int p,
                       input logic [3:0] rdy, input logic [1:0] g, input logic b,
                       input logic [15:0] d);
        vec_t t;
        t.valid = v; t.sop = s; t.eop = e; t.ordy = r; t.w = w;
        t.ovalid = ov; t.port = p; t.rdy = rdy; t.grant = g; t.busy = b; t.drop = d;
        vecs.push_back(t);
    endtask

    task automatic apply_row(input int r, input vec_t v);
        @(posedge clk); #1;
        drive(v.valid, v.sop, v.eop, v.ordy, v.w);
        @(negedge clk);
        check($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(v.ovalid));
        check($sformatf("row%0d in_ready", r), 32'(in_ready), 32'(v.rdy));
        check($sformatf("row%0d grant_idx", r), 32'(grant_idx), 32'(v.grant));
        check($sformatf("row%0d busy", r), 32'(busy), 32'(v.busy));
        check($sformatf("row%0d drop_cnt", r), 32'(drop_cnt), 32'(v.drop));
        if (v.ovalid) begin
            check($sformatf("row%0d out_data", r), out_data, port_word(v.port));
            check($sformatf("row%0d out_sop", r), 32'(out_sop), 32'(v.sop[v.port]));
            check($sformatf("row%0d out_eop", r), 32'(out_eop), 32'(v.eop[v.port]));
            check($sformatf("row%0d out_empty", r), 32'(out_empty), 32'(v.port % 4));
            check($sformatf("row%0d out_error", r), 32'(out_error), 32'(v.port % 2));
        end
        $display("row %0d: valid=%b sop=%b eop=%b ordy=%b -> out_valid=%b in_ready=%b grant=%0d busy=%b drop=%0d",
                 r, v.valid, v.sop, v.eop, v.ordy, out_valid, in_ready, grant_idx, busy, drop_cnt);
    endtask

    initial begin
        int acc_cnt;
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 1'b0, 16'h1111);

        // valid sop eop ordy weights | ovalid port in_ready grant busy drop
        // Equal weights: 2-beat and single-beat packets rotate 0,1,2,3,0.
        add(4'h0, 4'h0, 4'h0, 1, 16'h1111, 0, 0, 4'h0, 0, 0, 0);
        add(4'hF, 4'hF, 4'h0, 1, 16'h1111, 1, 0, 4'h1, 0, 0, 0);
        add(4'hF, 4'hE, 4'h1, 1, 16'h1111, 1, 0, 4'h1, 0, 1, 0);
        add(4'hF, 4'hF, 4'h0, 1, 16'h1111, 1, 1, 4'h2, 0, 0, 0);
        add(4'hF, 4'hD, 4'h2, 1, 16'h1111, 1, 1, 4'h2, 1, 1, 0);
        add(4'hF, 4'hF, 4'hC, 1, 16'h1111, 1, 2, 4'h4, 1, 0, 0);
        add(4'hF, 4'hF, 4'hC, 1, 16'h1111, 1, 3, 4'h8, 2, 0, 0);
        add(4'hF, 4'hF, 4'hC, 1, 16'h1111, 1, 0, 4'h1, 3, 0, 0);
        // Stall mid-packet, then EOP.
        add(4'hF, 4'hE, 4'h1, 0, 16'h1111, 1, 0, 4'h0, 0, 1, 0);
        add(4'hF, 4'hE, 4'h1, 1, 16'h1111, 1, 0, 4'h1, 0, 1, 0);
        // Stalled SOP in idle keeps out_valid, no commit.
        add(4'hF, 4'hF, 4'h0, 0, 16'h1111, 1, 1, 4'h0, 0, 0, 0);
        add(4'h4, 4'hF, 4'h0, 0, 16'h1111, 1, 2, 4'h0, 0, 0, 0);
        add(4'h4, 4'h4, 4'h4, 1, 16'h1111, 1, 2, 4'h4, 0, 0, 0);
        // Weighted turns: port0=3, port1=1.
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 2, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 1, 4'h2, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 1, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0013, 1, 1, 4'h2, 0, 0, 0);
        // Weight 5 sampled at turn start; lowering it mid-turn has no effect.
        add(4'h3, 4'h3, 4'h3, 1, 16'h0015, 1, 0, 4'h1, 1, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0011, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0011, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0011, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0011, 1, 0, 4'h1, 0, 0, 0);
        add(4'h3, 4'h3, 4'h3, 1, 16'h0011, 1, 1, 4'h2, 0, 0, 0);
        // Malformed beats on port 2 are dropped, even with out_ready low.
        add(4'h4, 4'h0, 4'h0, 1, 16'h0011, 0, 0, 4'h4, 1, 0, 0);
        add(4'h4, 4'h0, 4'h0, 1, 16'h0011, 0, 0, 4'h4, 1, 0, 1);
        add(4'h4, 4'h0, 4'h0, 0, 16'h0011, 0, 0, 4'h4, 1, 0, 2);
        add(4'h0, 4'h0, 4'h0, 1, 16'h0011, 0, 0, 4'h0, 1, 0, 3);
        // Skip and wrap: rr_ptr=2, ports 1 and 3 valid -> 3 then 1.
        add(4'hA, 4'hA, 4'hA, 1, 16'h0011, 1, 3, 4'h8, 1, 0, 3);
        add(4'hA, 4'hA, 4'hA, 1, 16'h0011, 1, 1, 4'h2, 3, 0, 3);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            apply_row(r, vecs[r]);
        end

        // Back-pressure: 5-beat packet on port 2 with out_ready toggling.
        acc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            drive(4'hF, (acc_cnt == 0) ? 4'hF : 4'hB, (acc_cnt == 4) ? 4'h4 : 4'h0,
                  (c % 2) == 1, 16'h0011);
            in_data[2*DW +: DW] = 32'hB000_0000 + 32'(acc_cnt);
            @(negedge clk);
            check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d out_data", c), out_data, 32'hB000_0000 + 32'(acc_cnt));
            check($sformatf("bp%0d in_ready", c), 32'(in_ready), ((c % 2) == 1) ? 32'h4 : 32'h0);
            check($sformatf("bp%0d busy", c), 32'(busy), 32'(acc_cnt > 0));
            $display("bp cycle %0d: ordy=%b out_valid=%b data=%h in_ready=%b busy=%b",
                     c, out_ready, out_valid, out_data, in_ready, busy);
            if (out_valid && out_ready && in_ready[2]) acc_cnt++;
        end
        check("bp beats accepted", 32'(acc_cnt), 32'd5);
        @(posedge clk); #1;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 16'h0011);
        @(negedge clk);
        check("bp busy after eop", 32'(busy), 32'd0);
        check("bp grant after eop", 32'(grant_idx), 32'd2);
        $display("bp done: beats=%0d busy=%b grant=%0d", acc_cnt, busy, grant_idx);

        // Drop counter saturation: 3 + 65532 drops reach 0xFFFF, then hold.
        @(posedge clk); #1;
        drive(4'h1, 4'h0, 4'h0, 1'b0, 16'h0011);
        repeat (65532) @(posedge clk);
        @(negedge clk);
        check("sat reach", 32'(drop_cnt), 32'h0000_FFFF);
        check("sat out_valid", 32'(out_valid), 32'd0);
        check("sat in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("sat hold", 32'(drop_cnt), 32'h0000_FFFF);
        $display("saturation: drop_cnt=%h", drop_cnt);

        // Reset mid-packet: rr_ptr=3, 4-beat packet on port 3.
        @(posedge clk); #1;
        drive(4'h8, 4'h8, 4'h0, 1'b1, 16'h0011);
        @(negedge clk);
        check("rst beat0 in_ready", 32'(in_ready), 32'h8);
        @(posedge clk); #1;
        drive(4'hA, 4'h2, 4'h2, 1'b1, 16'h0011);
        @(negedge clk);
        check("rst beat1 busy", 32'(busy), 32'd1);
        check("rst beat1 grant", 32'(grant_idx), 32'd3);
        check("rst beat1 data", out_data, port_word(3));
        #1 rst_n = 1'b0;
        #1;
        check("in rst out_valid", 32'(out_valid), 32'd0);
        check("in rst in_ready", 32'(in_ready), 32'h0);
        check("in rst grant", 32'(grant_idx), 32'd0);
        check("in rst busy", 32'(busy), 32'd0);
        check("in rst drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        check("in rst out_valid 2", 32'(out_valid), 32'd0);
        check("in rst in_ready 2", 32'(in_ready), 32'h0);
        $display("reset asserted: out_valid=%b in_ready=%b grant=%0d busy=%b drop=%0d",
                 out_valid, in_ready, grant_idx, busy, drop_cnt);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post rst out_valid", 32'(out_valid), 32'd1);
        check("post rst in_ready", 32'(in_ready), 32'h2);
        check("post rst data", out_data, port_word(1));
        check("post rst busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 16'h0011);
        @(negedge clk);
        check("post rst grant", 32'(grant_idx), 32'd1);
        $display("after reset: grant=%0d busy=%b", grant_idx, busy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
